// File: rtl/smu_pkg.sv
// Shared loader types and defaults: FSM state encoding, default sync word and CRC-8 polynomial.
// No logic, so no latency or backpressure.
package smu_pkg;
    localparam int CRC_W = 8;
    localparam logic [15:0] DEF_SYNC_WORD = 16'hA5C3;
    localparam logic [CRC_W-1:0] DEF_CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        HUNT,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } loaderState_t;
endpackage

// File: rtl/crc8_serial.sv
// Bit-serial, non-reflected CRC-8 with zero init; the state updates on the edge that samples the bit.
// No backpressure: the bit is absorbed whenever enable is high, and clear wins over enable.
module crc8_serial
    import smu_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = DEF_CRC_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bitIn,
    input  logic             clear,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ bitIn) ? POLY : '0);
        end
    end

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Hunts for a sync word, shifts in a CFG_SIZE payload plus CRC-8, and commits it atomically; the result flags rise 1 cycle after the last CRC bit.
// No backpressure: StreamValid low simply freezes all state for as long as it stays low.
module cfg_bitstream_loader
    import smu_pkg::*;
#(
    parameter int               CFG_SIZE  = 64,
    parameter logic [15:0]      SYNC_WORD = DEF_SYNC_WORD,
    parameter logic [CRC_W-1:0] CRC_POLY  = DEF_CRC_POLY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          SerialIn,
    input  logic                          StreamValid,
    output logic [CFG_SIZE-1:0]           ParallelOut,
    output logic                          CfgDone,
    output logic                          CfgError,
    output logic [$clog2(CFG_SIZE+1)-1:0] BitCount
);

    localparam int CNT_W = $clog2(CFG_SIZE + 1);

    loaderState_t        state;
    logic [15:0]         window;
    logic [CFG_SIZE-1:0] shadow;
    logic [CRC_W-1:0]    rxCrc;
    logic [2:0]          rxCnt;
    logic [CRC_W-1:0]    calcCrc;

    logic [15:0]      nextWindow;
    logic [CRC_W-1:0] nextRxCrc;

    assign nextWindow = {window[14:0], SerialIn};
    assign nextRxCrc  = {rxCrc[CRC_W-2:0], SerialIn};

    // Held cleared throughout HUNT so every frame starts its CRC from zero.
    crc8_serial #(.POLY(CRC_POLY)) uCrc (
        .clk    (clk),
        .rst    (rst),
        .enable (StreamValid && (state == LOAD)),
        .bitIn  (SerialIn),
        .clear  (state == HUNT),
        .crc    (calcCrc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            window      <= '0;
            shadow      <= '0;
            rxCrc       <= '0;
            rxCnt       <= '0;
            BitCount    <= '0;
            ParallelOut <= '0;
            CfgDone     <= 1'b0;
            CfgError    <= 1'b0;
        end else if (StreamValid) begin
            case (state)
                HUNT: begin
                    window <= nextWindow;
                    if (nextWindow == SYNC_WORD) begin
                        state    <= LOAD;
                        BitCount <= '0;
                    end
                end
                LOAD: begin
                    shadow   <= {shadow[CFG_SIZE-2:0], SerialIn};
                    BitCount <= BitCount + CNT_W'(1);
                    if (BitCount == CNT_W'(CFG_SIZE - 1)) begin
                        state <= CHECK;
                        rxCnt <= '0;
                    end
                end
                CHECK: begin
                    rxCrc <= nextRxCrc;
                    rxCnt <= rxCnt + 3'd1;
                    if (rxCnt == 3'd7) begin
                        if (nextRxCrc == calcCrc) begin
                            ParallelOut <= shadow;
                            CfgDone     <= 1'b1;
                            state       <= DONE;
                        end else begin
                            CfgError <= 1'b1;
                            state    <= ERROR;
                        end
                    end
                end
                DONE, ERROR: ;
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Directed bench for cfg_bitstream_loader with a history-based reference model checked every cycle.
module tb_cfg_bitstream_loader;
    localparam int CFG = 16;
    localparam int BCW = $clog2(CFG + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           SerialIn = 1'b0;
    logic           StreamValid = 1'b0;
    logic [CFG-1:0] ParallelOut;
    logic           CfgDone;
    logic           CfgError;
    logic [BCW-1:0] BitCount;

    int tests = 0;
    int fails = 0;
    bit started = 0;
    bit hist[$];

    cfg_bitstream_loader #(.CFG_SIZE(CFG)) dut (
        .clk         (clk),
        .rst         (rst),
        .SerialIn    (SerialIn),
        .StreamValid (StreamValid),
        .ParallelOut (ParallelOut),
        .CfgDone     (CfgDone),
        .CfgError    (CfgError),
        .BitCount    (BitCount)
    );

    always #5 clk = ~clk;

    // Reference: everything the DUT should show is a function of the valid bits seen since reset.
    always @(posedge clk) begin
        if (rst) hist.delete();
        else if (StreamValid) hist.push_back(SerialIn);
        started = 1;
    end

    function automatic logic [7:0] crcOf(input logic [CFG-1:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int k = CFG/8 - 1; k >= 0; k--) begin
            c = c ^ p[k*8 +: 8];
            for (int j = 0; j < 8; j++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic modelOut(output logic [CFG-1:0] p, output logic d, output logic e, output int bc);
        int syncEnd;
        int rem;
        logic [15:0] w;
        logic [CFG-1:0] pl;
        logic [7:0] rc;
        syncEnd = -1;
        p = '0; d = 1'b0; e = 1'b0; bc = 0;
        for (int i = 15; i < hist.size() && syncEnd < 0; i++) begin
            for (int k = 0; k < 16; k++) w[15-k] = hist[i-15+k];
            if (w == 16'hA5C3) syncEnd = i;
        end
        if (syncEnd >= 0) begin
            rem = hist.size() - 1 - syncEnd;
            bc = (rem < CFG) ? rem : CFG;
            if (rem >= CFG + 8) begin
                for (int k = 0; k < CFG; k++) pl[CFG-1-k] = hist[syncEnd+1+k];
                for (int k = 0; k < 8; k++) rc[7-k] = hist[syncEnd+1+CFG+k];
                if (rc == crcOf(pl)) begin
                    d = 1'b1;
                    p = pl;
                end else begin
                    e = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [CFG-1:0] ep;
        logic ed, ee;
        int ebc;
        if (started) begin
            modelOut(ep, ed, ee, ebc);
            check("model ParallelOut", 32'(ParallelOut), 32'(ep));
            check("model CfgDone", 32'(CfgDone), 32'(ed));
            check("model CfgError", 32'(CfgError), 32'(ee));
            check("model BitCount", 32'(BitCount), 32'(ebc));
            check("done/error exclusive", 32'(CfgDone & CfgError), 32'd0);
        end
    end

    task automatic sendBit(input logic b);
        @(negedge clk);
        StreamValid = 1'b1;
        SerialIn = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            StreamValid = 1'b0;
            SerialIn = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic sendBits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sendBit(v[i]);
    endtask

    task automatic sendFrame(input logic [15:0] pl, input logic [7:0] c);
        sendBits(32'hA5C3, 16);
        sendBits(32'(pl), 16);
        sendBits(32'(c), 8);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        StreamValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [39:0] frame;
        int g0, g1, g2;

        repeat (3) @(negedge clk);
        check("reset ParallelOut", 32'(ParallelOut), 32'h0);
        check("reset CfgDone", 32'(CfgDone), 32'h0);
        check("reset CfgError", 32'(CfgError), 32'h0);
        check("reset BitCount", 32'(BitCount), 32'h0);
        rst = 1'b0;

        // Good frame; flags must still be low while the last CRC bit is being presented.
        sendFrame(16'h1234, 8'hF1);
        check("good done before last edge", 32'(CfgDone), 32'h0);
        idle(1);
        check("good ParallelOut", 32'(ParallelOut), 32'h1234);
        check("good CfgDone", 32'(CfgDone), 32'h1);
        check("good CfgError", 32'(CfgError), 32'h0);
        check("good BitCount", 32'(BitCount), 32'd16);

        // Bad CRC, then a good frame that must be ignored.
        doReset();
        sendFrame(16'h1234, 8'hF0);
        idle(1);
        check("badcrc CfgError", 32'(CfgError), 32'h1);
        check("badcrc CfgDone", 32'(CfgDone), 32'h0);
        check("badcrc ParallelOut", 32'(ParallelOut), 32'h0);
        sendFrame(16'h1234, 8'hF1);
        idle(2);
        check("after error ParallelOut", 32'(ParallelOut), 32'h0);
        check("after error CfgDone", 32'(CfgDone), 32'h0);

        // Good frame with three idle cycles at random bit positions.
        doReset();
        frame = {16'hA5C3, 16'h1234, 8'hF1};
        g0 = $urandom_range(1, 39);
        g1 = $urandom_range(1, 39);
        g2 = $urandom_range(1, 39);
        for (int i = 0; i < 40; i++) begin
            if (i == g0) idle(1);
            if (i == g1) idle(1);
            if (i == g2) idle(1);
            sendBit(frame[39-i]);
        end
        idle(1);
        check("gaps ParallelOut", 32'(ParallelOut), 32'h1234);
        check("gaps CfgDone", 32'(CfgDone), 32'h1);

        // Alternating noise ahead of the true sync word.
        doReset();
        for (int i = 0; i < 20; i++) sendBit(1'(i % 2));
        check("noise BitCount", 32'(BitCount), 32'h0);
        sendFrame(16'h1234, 8'hF1);
        idle(1);
        check("noise ParallelOut", 32'(ParallelOut), 32'h1234);
        check("noise CfgDone", 32'(CfgDone), 32'h1);

        // Reset in the middle of a payload, then a complete BEEF frame.
        doReset();
        sendBits(32'hA5C3, 16);
        sendBits(32'h1234 >> 7, 9);
        idle(1);
        check("partial BitCount", 32'(BitCount), 32'd9);
        doReset();
        check("midreset BitCount", 32'(BitCount), 32'h0);
        check("midreset ParallelOut", 32'(ParallelOut), 32'h0);
        sendFrame(16'hBEEF, crcOf(16'hBEEF));
        idle(1);
        check("beef ParallelOut", 32'(ParallelOut), 32'hBEEF);
        check("beef CfgDone", 32'(CfgDone), 32'h1);

        // Payload equal to the sync word, followed by a frame that must be ignored.
        doReset();
        sendFrame(16'hA5C3, crcOf(16'hA5C3));
        idle(1);
        sendFrame(16'h1234, 8'hF1);
        idle(2);
        check("syncpayload ParallelOut", 32'(ParallelOut), 32'hA5C3);
        check("syncpayload CfgDone", 32'(CfgDone), 32'h1);
        check("syncpayload BitCount", 32'(BitCount), 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cfg_bitstream_loader.md
CFG_BITSTREAM_LOADER -- requirements
Module: cfg_bitstream_loader

Interface
REQ-001 SHALL have parameter CFG_SIZE, default 64: payload width in bits; legal range 8..4096.
REQ-002 SHALL have parameter SYNC_WORD, default 16'hA5C3: frame start pattern.
REQ-003 SHALL have parameter CRC_POLY, default 8'h07: CRC-8 polynomial, non-reflected, init 8'h00.
REQ-004 SHALL have port clk, input, 1 bit: single clock. All logic is on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port SerialIn, input, 1 bit: bitstream data, sampled only when StreamValid=1.
REQ-007 SHALL have port StreamValid, input, 1 bit: SerialIn is valid this cycle.
REQ-008 SHALL have port ParallelOut, output, CFG_SIZE bits: committed configuration, feeding the downstream decrypt/SMU config array.
REQ-009 SHALL have port CfgDone, output, 1 bit: sticky, asserted once a frame has been committed.
REQ-010 SHALL have port CfgError, output, 1 bit: sticky, asserted on CRC mismatch.
REQ-011 SHALL have port BitCount, output, $clog2(CFG_SIZE+1) bits: number of payload bits received in the current frame (debug).

Function
REQ-012 SHALL implement FSM states HUNT, LOAD, CHECK, DONE and ERROR.
REQ-013 SHALL enter HUNT after reset.
REQ-014 SHALL, in HUNT, shift each valid bit into a 16-bit window; when window equals SYNC_WORD (including the bit just sampled), go to LOAD next cycle with counter and CRC cleared.
REQ-015 SHALL, in LOAD, shift each valid bit MSB-first into a CFG_SIZE shadow register, so the first payload bit lands in ParallelOut[CFG_SIZE-1].
REQ-016 SHALL update CRC per valid payload bit: fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? CRC_POLY : 0).
REQ-017 SHALL, after the CFG_SIZE-th payload bit, go to CHECK with the receive-CRC counter cleared.
REQ-018 SHALL, in CHECK, shift 8 valid bits MSB-first into a received-CRC register; the computed CRC SHALL be frozen during CHECK.
REQ-019 SHALL, on the 8th CHECK bit: if the CRCs match, load ParallelOut from shadow and set CfgDone on the next edge, then enter DONE; otherwise set CfgError and enter ERROR.
REQ-020 SHALL ignore all further input in DONE and ERROR until reset; ParallelOut holds its value.
REQ-021 SHALL freeze state, counters and shift registers when StreamValid=0; gaps of any length are legal.
REQ-022 SHALL never change ParallelOut except at commit; it reads all-zero before the first commit and is never partially updated.
REQ-023 SHALL keep CfgDone and CfgError mutually exclusive.
REQ-024 SHALL have a latency of 1 cycle from the last CRC bit sampled to CfgDone or CfgError high.
REQ-025 SHALL not rescan a sync pattern appearing inside the payload or CRC.

Reset
REQ-026 SHALL, while rst=1, clear ParallelOut, shadow register, window, CRC, counters, CfgDone, CfgError and BitCount, and force state to HUNT; rst overrides StreamValid.
REQ-027 SHALL, on reset asserted mid-frame, discard the partial frame; the next frame loads from HUNT normally.

Structure
REQ-028 SHALL place the state enum, default SYNC_WORD, default CRC_POLY and the CRC width constant (8) in the shared smu_pkg package.
REQ-029 SHALL implement the bitwise CRC-8 update as one sub-module, crc8_serial: enable, bit in, clear, 8-bit state.

Verification
REQ-030 SHALL cover (CFG_SIZE=16): sync A5C3, payload 16'h1234, CRC 8'hF1 -> CfgDone=1 one cycle after the last bit, ParallelOut=16'h1234, CfgError=0.
REQ-031 SHALL cover: same frame with CRC 8'hF0 -> CfgError=1, CfgDone=0, ParallelOut=16'h0000, later frames ignored.
REQ-032 SHALL cover: same good frame with StreamValid low for 3 random cycles between bits -> identical result to REQ-030.
REQ-033 SHALL cover: 20 noise bits 0101..., then a good frame -> lock only on the true sync; ParallelOut=16'h1234.
REQ-034 SHALL cover: rst pulsed after 9 payload bits, then a full good frame with payload 16'hBEEF and correct CRC -> CfgDone=1, ParallelOut=16'hBEEF.
REQ-035 SHALL cover: payload 16'hA5C3 with correct CRC, then a second frame after DONE -> first payload committed, second ignored, BitCount stays 16.
